// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - CPU bus register addresses and sprite DMA state encoding
package nes_bus_pkg;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_RD,
    DMA_WR
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer copying one CPU page to OAMDATA
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   cpu_addr/we/wdata       CPU bus, watched for the page-number write in IDLE
//   cpu_odd                 CPU cycle parity, sampled in HALT for alignment
//   bus_rdata               read data from the address decoder for dma_addr
//   cpu_rdy                 0 while the CPU is halted
//   dma_own                 1 while the DMA drives the bus
//   dma_addr/we/wdata       DMA bus cycle (page read, then OAMDATA write)
//   dma_busy                transfer in progress
//
// Configuration macro: OAM_DMA_ALIGN_EN adds the ALIGN dummy cycle on odd starts.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter int XFER_LEN = 256,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_odd,
  input  logic [7:0]        bus_rdata,
  output logic              cpu_rdy,
  output logic              dma_own,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_we,
  output logic [7:0]        dma_wdata,
  output logic              dma_busy
);

  localparam int CNT_W = $clog2(XFER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_LEN - 1);

  dma_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [7:0]        page, page_d;
  logic [7:0]        wdata_d;
  logic              own_d, we_d, rdy_d;
  logic [ADDR_W-1:0] addr_d;

`ifndef OAM_DMA_ALIGN_EN
  logic unused_cpu_odd;
  assign unused_cpu_odd = cpu_odd;
`endif

  // Next state, counter, page and captured byte.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    page_d  = page;
    wdata_d = dma_wdata;
    case (state)
      DMA_IDLE: begin
        if (cpu_we && (cpu_addr == ADDR_W'(ADDR_OAMDMA))) begin
          state_d = DMA_HALT;
          page_d  = cpu_wdata;
          cnt_d   = '0;
        end
      end
      DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        state_d = cpu_odd ? DMA_ALIGN : DMA_RD;
`else
        state_d = DMA_RD;
`endif
      end
      DMA_ALIGN: state_d = DMA_RD;
      DMA_RD: begin
        wdata_d = bus_rdata;
        state_d = DMA_WR;
      end
      DMA_WR: begin
        cnt_d   = cnt + CNT_W'(1);
        // The last byte ends the transfer; the wrapped counter never reaches the page.
        state_d = (cnt == CNT_LAST) ? DMA_IDLE : DMA_RD;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    own_d  = (state_d == DMA_RD) || (state_d == DMA_WR);
    we_d   = (state_d == DMA_WR);
    rdy_d  = (state_d == DMA_IDLE);
    addr_d = '0;
    if (state_d == DMA_RD) begin
      addr_d = ADDR_W'({page_d, 8'h00}) | ADDR_W'(cnt_d);
    end else if (state_d == DMA_WR) begin
      addr_d = ADDR_W'(ADDR_OAMDATA);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= DMA_IDLE;
      cnt       <= '0;
      page      <= '0;
      cpu_rdy   <= 1'b1;
      dma_own   <= 1'b0;
      dma_we    <= 1'b0;
      dma_addr  <= '0;
      dma_wdata <= '0;
      dma_busy  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      page      <= page_d;
      cpu_rdy   <= rdy_d;
      dma_own   <= own_d;
      dma_we    <= we_d;
      dma_addr  <= addr_d;
      dma_wdata <= wdata_d;
      dma_busy  <= !rdy_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_odd;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_own;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } xact_t;

  xact_t exp_q[$];
  logic [7:0] ram [0:65535];

  always #5 clk = ~clk;

  assign bus_rdata = ram[dma_addr];

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_odd   (cpu_odd),
    .bus_rdata (bus_rdata),
    .cpu_rdy   (cpu_rdy),
    .dma_own   (dma_own),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .dma_busy  (dma_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DMA owns the bus must match the next expected access.
  always @(negedge clk) begin
    if (dma_own) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_access: got addr %0h we %0b, expected no access", dma_addr, dma_we);
      end else begin
        xact_t e;
        e = exp_q.pop_front();
        if (dma_addr !== e.addr || dma_we !== e.we || (e.we && dma_wdata !== e.data)) begin
          n_errors++;
          $display("FAIL bus_access: got addr %0h we %0b data %0h, expected addr %0h we %0b data %0h",
                   dma_addr, dma_we, dma_wdata, e.addr, e.we, e.data);
        end
      end
    end
  end

  task automatic push_xfer(input logic [7:0] page, input int n_bytes, input bit extra_rd);
    xact_t e;
    for (int i = 0; i < n_bytes; i++) begin
      e.addr = {page, 8'(i)};
      e.we   = 1'b0;
      e.data = 8'h00;
      exp_q.push_back(e);
      e.addr = 16'h2004;
      e.we   = 1'b1;
      e.data = ram[{page, 8'(i)}];
      exp_q.push_back(e);
    end
    if (extra_rd) begin
      e.addr = {page, 8'(n_bytes)};
      e.we   = 1'b0;
      e.data = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic trigger(input logic [7:0] page, input logic odd);
    @(negedge clk);
    cpu_addr  = 16'h4014;
    cpu_we    = 1'b1;
    cpu_wdata = page;
    cpu_odd   = odd;
    @(negedge clk);
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  // Full transfer; optionally fires a bogus $4014 write while the CPU is stalled.
  task automatic run_dma(input logic [7:0] page, input logic odd, input int exp_stall,
                         input bit inject);
    int stall;
    push_xfer(page, 256, 1'b0);
    trigger(page, odd);
    stall = 0;
    while (!cpu_rdy && stall < 2000) begin
      stall++;
      if (inject && stall == 10) begin
        cpu_addr  = 16'h4014;
        cpu_we    = 1'b1;
        cpu_wdata = 8'h77;
      end
      if (inject && stall == 14) begin
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
      end
      @(negedge clk);
    end
    cpu_odd = 1'b0;
    check("stall_cycles", stall, exp_stall);
    check("queue_drained", exp_q.size(), 0);
    check("busy_clear", dma_busy, 1'b0);
  endtask

  int exp_odd_stall;
  int waited;

  initial begin
`ifdef OAM_DMA_ALIGN_EN
    exp_odd_stall = 514;
`else
    exp_odd_stall = 513;
`endif
    for (int i = 0; i < 256; i++) begin
      ram[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
      ram[{8'hFF, 8'(i)}] = 8'(i) ^ 8'h3C;
      ram[{8'h03, 8'(i)}] = 8'(i + 7);
      ram[{8'h05, 8'(i)}] = ~8'(i);
      ram[{8'h00, 8'(i)}] = 8'hEE;
    end
    reset_n   = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_we    = 1'b0;
    cpu_wdata = 8'h00;
    cpu_odd   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_rdy", cpu_rdy, 1'b1);
    check("rst_dma_own", dma_own, 1'b0);
    check("rst_dma_we", dma_we, 1'b0);
    check("rst_dma_addr", dma_addr, 16'h0000);
    check("rst_dma_wdata", dma_wdata, 8'h00);
    check("rst_dma_busy", dma_busy, 1'b0);
    reset_n = 1'b1;

    // Idle for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_cpu_rdy", cpu_rdy, 1'b1);
      check("idle_dma_own", dma_own, 1'b0);
    end

    // Even and odd starts.
    run_dma(8'h02, 1'b0, 513, 1'b0);
    run_dma(8'h02, 1'b1, exp_odd_stall, 1'b0);

    // Top page: ends at $FFFF with no carry into $0000.
    run_dma(8'hFF, 1'b0, 513, 1'b0);
    repeat (4) @(negedge clk);
    check("ff_no_wrap_own", dma_own, 1'b0);

    // Reset during the read of byte 100.
    push_xfer(8'h03, 100, 1'b1);
    trigger(8'h03, 1'b0);
    waited = 0;
    while (!(dma_own && !dma_we && dma_addr == 16'h0364) && waited < 1000) begin
      waited++;
      @(negedge clk);
    end
    check("reach_byte100", (waited < 1000), 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_dma_own", dma_own, 1'b0);
    check("midrst_cpu_rdy", cpu_rdy, 1'b1);
    check("midrst_dma_busy", dma_busy, 1'b0);
    check("midrst_dma_addr", dma_addr, 16'h0000);
    check("midrst_dma_we", dma_we, 1'b0);
    reset_n = 1'b1;
    check("midrst_queue", exp_q.size(), 0);
    run_dma(8'h03, 1'b0, 513, 1'b0);

    // $4014 write while stalled is ignored; the page stays $05.
    run_dma(8'h05, 1'b0, 513, 1'b1);

    // Neighbour registers and a $4014 read in IDLE start nothing.
    @(negedge clk);
    cpu_addr = 16'h4013; cpu_we = 1'b1; cpu_wdata = 8'h02;
    @(negedge clk);
    cpu_addr = 16'h4015; cpu_we = 1'b1;
    @(negedge clk);
    cpu_addr = 16'h4014; cpu_we = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h0000; cpu_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nontrigger_rdy", cpu_rdy, 1'b1);
      check("nontrigger_busy", dma_busy, 1'b0);
    end
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
